// File: rtl/instr_mem_port.sv
// Writable instruction memory with a pipelined fetch port, a two-entry in-order response
// buffer, a program-load write port and a clear sequencer that fills the array with DefaultWord.
module instr_mem_port #(
    parameter int unsigned             DataWidth   = 16,
    parameter int unsigned             AddrWidth   = 10,
    parameter int unsigned             Depth       = 1024,
    parameter logic [DataWidth-1:0]    DefaultWord = 16'h0000
) (
    input  logic                 clk,
    input  logic                 async_rst_n,
    input  logic                 FetchReq,
    input  logic [AddrWidth-1:0] FetchAddr,
    output logic                 FetchReady,
    output logic                 RespValid,
    output logic [DataWidth-1:0] RespData,
    output logic                 RespFault,
    input  logic                 RespReady,
    input  logic                 WriteEn,
    input  logic [AddrWidth-1:0] WriteAddr,
    input  logic [DataWidth-1:0] WriteData,
    input  logic                 ClearReq,
    output logic                 Busy
);

    localparam int unsigned           IdxW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [AddrWidth:0]    DepthL  = (AddrWidth + 1)'(Depth);
    localparam logic [AddrWidth-1:0]  LastIdx = AddrWidth'(Depth - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e               state_r;
    logic [AddrWidth-1:0] clr_cnt_r;
    logic                 fetch_ready_r;
    logic                 busy_r;

    logic [DataWidth-1:0] mem_r [Depth];

    // Entry 0 is always the head; entry 1 is only valid when entry 0 is.
    logic                 v0_r, v1_r, f0_r, f1_r;
    logic [DataWidth-1:0] d0_r, d1_r;
    logic                 v0_s, v1_s, f0_s, f1_s;
    logic [DataWidth-1:0] d0_s, d1_s;

    logic                 accept_s;
    logic                 pop_s;
    logic                 fault_s;
    logic                 wr_ok_s;
    logic [DataWidth-1:0] push_data_s;

    // Fetch decode: the array is read combinationally so the word is captured read-first at the accept edge.
    always_comb begin
        accept_s    = FetchReq && fetch_ready_r;
        pop_s       = v0_r && RespReady;
        fault_s     = ({1'b0, FetchAddr} >= DepthL);
        wr_ok_s     = WriteEn && ({1'b0, WriteAddr} < DepthL);
        if (fault_s) begin
            push_data_s = DefaultWord;
        end else begin
            push_data_s = mem_r[FetchAddr[IdxW-1:0]];
        end
    end

    // Response buffer next state: pop shifts entry 1 down, then a push fills the first free slot.
    always_comb begin
        v0_s = v0_r;
        v1_s = v1_r;
        d0_s = d0_r;
        d1_s = d1_r;
        f0_s = f0_r;
        f1_s = f1_r;
        if (pop_s) begin
            v0_s = v1_r;
            d0_s = d1_r;
            f0_s = f1_r;
            v1_s = 1'b0;
        end else begin
            v1_s = v1_r;
        end
        if (accept_s) begin
            if (!v0_s) begin
                v0_s = 1'b1;
                d0_s = push_data_s;
                f0_s = fault_s;
            end else begin
                v1_s = 1'b1;
                d1_s = push_data_s;
                f1_s = fault_s;
            end
        end else begin
            v0_s = v0_s;
        end
    end

    // Array write port: the clear sequencer owns the array while clearing, program loads otherwise.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_cnt_r[IdxW-1:0]] <= DefaultWord;
        end else if (wr_ok_s) begin
            mem_r[WriteAddr[IdxW-1:0]] <= WriteData;
        end
    end

    // Control FSM, clear counter, response buffer and registered handshake outputs.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_r       <= ST_CLEAR;
            clr_cnt_r     <= {AddrWidth{1'b0}};
            fetch_ready_r <= 1'b0;
            busy_r        <= 1'b1;
            v0_r          <= 1'b0;
            v1_r          <= 1'b0;
            d0_r          <= DefaultWord;
            d1_r          <= DefaultWord;
            f0_r          <= 1'b0;
            f1_r          <= 1'b0;
        end else begin
            v0_r <= v0_s;
            v1_r <= v1_s;
            d0_r <= d0_s;
            d1_r <= d1_s;
            f0_r <= f0_s;
            f1_r <= f1_s;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LastIdx) begin
                        state_r       <= ST_RUN;
                        clr_cnt_r     <= {AddrWidth{1'b0}};
                        fetch_ready_r <= !v1_s;
                        busy_r        <= 1'b0;
                    end else begin
                        clr_cnt_r     <= clr_cnt_r + AddrWidth'(1);
                        fetch_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (ClearReq) begin
                        state_r       <= ST_DRAIN;
                        fetch_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                    end else begin
                        fetch_ready_r <= !v1_s;
                        busy_r        <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (!v0_r) begin
                        state_r   <= ST_CLEAR;
                        clr_cnt_r <= {AddrWidth{1'b0}};
                    end else begin
                        state_r   <= ST_DRAIN;
                    end
                    fetch_ready_r <= 1'b0;
                    busy_r        <= 1'b1;
                end
                default: begin
                    state_r       <= ST_CLEAR;
                    clr_cnt_r     <= {AddrWidth{1'b0}};
                    fetch_ready_r <= 1'b0;
                    busy_r        <= 1'b1;
                end
            endcase
        end
    end

    assign FetchReady = fetch_ready_r;
    assign RespValid  = v0_r;
    assign RespData   = d0_r;
    assign RespFault  = f0_r;
    assign Busy       = busy_r;

endmodule
